// File: rtl/sdpb_pingpong_ctrl_if.sv
// Producer/reader handshake bundle for the ping-pong bank controller.
// The master drives words and read requests; the slave is the controller.
interface sdpb_pingpong_ctrl_if #(
   parameter int DATA_WIDTH = 128
);
   logic                  wr_valid;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ready;
   logic                  rd_start;
   logic                  rd_avail;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_done;

   modport master (
      output wr_valid, wr_data, rd_start,
      input  wr_ready, rd_avail, rd_valid, rd_data, rd_done
   );

   modport slave (
      input  wr_valid, wr_data, rd_start,
      output wr_ready, rd_avail, rd_valid, rd_data, rd_done
   );
endinterface

// File: rtl/sdpb_pingpong_ctrl.sv
// Two-bank ping-pong controller over a simple dual-port block RAM.
// Define SDPB_CTRL_OVERRUN_CNT_EN to count dropped producer words.
module sdpb_pingpong_ctrl #(
   parameter int WORDS_PER_BANK = 60,
   parameter int DATA_WIDTH     = 128,
   parameter int READ_LATENCY   = 2,
   localparam int AW = $clog2(2*WORDS_PER_BANK)
) (
   input  logic                  clk,
   input  logic                  reset,
   sdpb_pingpong_ctrl_if.slave   bus,
   output logic [15:0]           overrun_cnt,
   output logic                  cea,
   output logic                  reseta,
   output logic [AW-1:0]         ada,
   output logic [DATA_WIDTH-1:0] din,
   output logic                  ceb,
   output logic                  resetb,
   output logic                  oce,
   output logic [AW-1:0]         adb,
   input  logic [DATA_WIDTH-1:0] dout
);
   localparam int WIW = (WORDS_PER_BANK > 1) ? $clog2(WORDS_PER_BANK) : 1;
   localparam int PW  = READ_LATENCY;
   localparam logic [WIW-1:0] IDX_LAST = WIW'(WORDS_PER_BANK - 1);
   localparam logic [AW-1:0]  BANK1    = AW'(WORDS_PER_BANK);

   typedef enum logic [1:0] {
      R_IDLE,
      R_ISSUE,
      R_DRAIN
   } rstate_e;

   rstate_e        state_q, state_d;
   logic           wb_q, wb_d;
   logic           rb_q, rb_d;
   logic [1:0]     full_q, full_d;
   logic [WIW-1:0] wi_q, wi_d;
   logic [WIW-1:0] ri_q, ri_d;
   logic [PW-1:0]  vld_q, vld_d;
   logic [PW-1:0]  last_q, last_d;

   logic wr_ready;
   logic accept;
   logic rd_avail;
   logic rd_done;
   logic issue_last;

   always_comb begin
      wr_ready   = !full_q[wb_q];
      accept     = bus.wr_valid & wr_ready;
      rd_avail   = (state_q == R_IDLE) & full_q[rb_q];
      rd_done    = last_q[PW-1];
      cea        = accept;
      ada        = (wb_q ? BANK1 : '0) + AW'(wi_q);
      din        = bus.wr_data;
      ceb        = 1'b0;
      adb        = (rb_q ? BANK1 : '0) + AW'(ri_q);
      issue_last = 1'b0;
      state_d    = state_q;
      wb_d       = wb_q;
      rb_d       = rb_q;
      full_d     = full_q;
      wi_d       = wi_q;
      ri_d       = ri_q;

      if (accept) begin
         if (wi_q == IDX_LAST) begin
            wi_d         = '0;
            wb_d         = ~wb_q;
            full_d[wb_q] = 1'b1;
         end else begin
            wi_d = wi_q + 1'b1;
         end
      end

      unique case (state_q)
         R_IDLE: begin
            if (bus.rd_start && rd_avail) state_d = R_ISSUE;
         end
         R_ISSUE: begin
            ceb = 1'b1;
            if (ri_q == IDX_LAST) begin
               ri_d       = '0;
               issue_last = 1'b1;
               state_d    = R_DRAIN;
            end else begin
               ri_d = ri_q + 1'b1;
            end
         end
         R_DRAIN: begin
            // Release the bank only when its final word leaves the RAM.
            if (rd_done) begin
               state_d      = R_IDLE;
               full_d[rb_q] = 1'b0;
               rb_d         = ~rb_q;
            end
         end
         default: state_d = R_IDLE;
      endcase

      vld_d  = PW'({vld_q, ceb});
      last_d = PW'({last_q, issue_last});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= R_IDLE;
         wb_q    <= 1'b0;
         rb_q    <= 1'b0;
         full_q  <= '0;
         wi_q    <= '0;
         ri_q    <= '0;
         vld_q   <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         wb_q    <= wb_d;
         rb_q    <= rb_d;
         full_q  <= full_d;
         wi_q    <= wi_d;
         ri_q    <= ri_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
      end
   end

   assign bus.wr_ready = wr_ready;
   assign bus.rd_avail = rd_avail;
   assign bus.rd_valid = vld_q[PW-1];
   assign bus.rd_data  = dout;
   assign bus.rd_done  = rd_done;
   assign oce          = 1'b1;
   assign reseta       = reset;
   assign resetb       = reset;

`ifdef SDPB_CTRL_OVERRUN_CNT_EN
   logic [15:0] ovr_q, ovr_d;

   always_comb begin
      ovr_d = ovr_q;
      if (bus.wr_valid && !wr_ready && ovr_q != 16'hFFFF)
         ovr_d = ovr_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) ovr_q <= '0;
      else       ovr_q <= ovr_d;
   end

   assign overrun_cnt = ovr_q;
`else
   assign overrun_cnt = '0;
`endif
endmodule

// File: doc/sdpb_pingpong_ctrl.md
SDPB_PINGPONG_CTRL -- requirements
Module: sdpb_pingpong_ctrl

Interface
REQ-001 Parameter WORDS_PER_BANK, default 60; words per bank; RAM depth is 2*WORDS_PER_BANK.
REQ-002 Parameter DATA_WIDTH, default 128; word width.
REQ-003 Parameter READ_LATENCY, default 2, legal 1..2; cycles from ceb-qualified address to valid dout.
REQ-004 Derived AW = $clog2(2*WORDS_PER_BANK).
REQ-005 clk  in  1  single clock for all logic and both RAM ports.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 wr_valid  in  1  producer word valid.
REQ-008 wr_data  in  DATA_WIDTH  producer word.
REQ-009 wr_ready  out  1  controller accepts word this cycle.
REQ-010 rd_start  in  1  pulse requesting read-out of one full bank.
REQ-011 rd_avail  out  1  a full bank is waiting and the reader is idle.
REQ-012 rd_valid  out  1  rd_data is valid.
REQ-013 rd_data  out  DATA_WIDTH  word read from RAM.
REQ-014 rd_done  out  1  one-cycle pulse with the last rd_valid of a bank.
REQ-015 overrun_cnt  out  16  count of dropped producer words.
REQ-016 RAM port A: cea, reseta out 1; ada out AW; din out DATA_WIDTH.
REQ-017 RAM port B: ceb, resetb, oce out 1; adb out AW; dout in DATA_WIDTH.

Function
REQ-018 Bank b occupies addresses b*WORDS_PER_BANK .. b*WORDS_PER_BANK+WORDS_PER_BANK-1.
REQ-019 State: write bank wb, read bank rb, flags full[1:0], write index wi, read index ri.
REQ-020 wr_ready = !full[wb]; accept = wr_valid & wr_ready.
REQ-021 On accept: cea=1, ada=wb*WORDS_PER_BANK+wi, din=wr_data, same cycle (combinational), wi increments.
REQ-022 On accept with wi==WORDS_PER_BANK-1: wi wraps to 0, full[wb] sets, wb toggles.
REQ-023 Read FSM states R_IDLE, R_ISSUE, R_DRAIN.
REQ-024 rd_avail = (state==R_IDLE) & full[rb].
REQ-025 R_IDLE -> R_ISSUE when rd_start & rd_avail; rd_start ignored otherwise, no queuing.
REQ-026 R_ISSUE: ceb=1, adb=rb*WORDS_PER_BANK+ri each cycle, ri increments; after ri==WORDS_PER_BANK-1 issued, ri wraps to 0, -> R_DRAIN.
REQ-027 rd_valid is ceb delayed READ_LATENCY cycles; rd_data = dout.
REQ-028 R_DRAIN -> R_IDLE in the cycle the last rd_valid is high; that cycle rd_done=1, full[rb] clears, rb toggles.
REQ-029 Bank read throughput 1 word/cycle; rd_start to first rd_valid = 1+READ_LATENCY cycles.
REQ-030 Simultaneous write-set of full[wb] and read-clear of full[rb] (different banks) both take effect.
REQ-031 Freed bank makes wr_ready high the following cycle, not combinationally.
REQ-032 oce is constant 1; reseta = resetb = reset.
REQ-033 Write never targets bank rb while read is active; guaranteed by full flags.

Reset
REQ-034 Reset sets wb=rb=0, full=0, wi=ri=0, read FSM R_IDLE, delay pipeline cleared, overrun_cnt=0.
REQ-035 After reset: wr_ready=1, rd_avail=0, rd_valid=0, rd_done=0, cea=ceb=0.
REQ-036 Reset mid-read discards in-flight words; no rd_valid or rd_done follows.

Configuration
REQ-037 Macro SDPB_CTRL_OVERRUN_CNT_EN defined: overrun_cnt increments on wr_valid & !wr_ready, saturating at 16'hFFFF.
REQ-038 Macro undefined: overrun_cnt tied to 0, no counter logic.

Verification
REQ-039 Reset, write 60 words 0..59 -> full[0]=1, rd_avail=1, wb=1, wr_ready stays 1.
REQ-040 rd_start after REQ-039 -> rd_valid 60 consecutive cycles starting 3 cycles later (READ_LATENCY=2), data 0..59, rd_done with word 59.
REQ-041 Write 120 words with no read -> wr_ready=0 after word 119; 5 more wr_valid -> overrun_cnt=5 with macro, 0 without.
REQ-042 Read bank 0 while writing bank 1 continuously, last write and rd_done in same cycle -> full=2'b10, rb=1, wr_ready=1 next cycle.
REQ-043 rd_start with full=0 -> no ceb, rd_valid stays 0, FSM stays R_IDLE.
REQ-044 Reset at read word 30 -> rd_valid=0 next cycle, rd_done never pulses, rd_avail=0.
